aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
- Upstream feeder for the AES core's encrypt/decrypt data inputs (pt_encr/ct_decr with pt_valid/ct_valid).
- Accepts a 32-bit word stream with valid/ready handshake and a last-word marker.
- Assembles 128-bit AES blocks, zero-fills or pads the final partial block, and buffers finished blocks in a small block FIFO.
- Presents buffered blocks to the core through a valid/ready handshake.

Parameters:
- DEPTH, 2, number of 128-bit blocks buffered; power of 2, minimum 2.
- CNT_W, 2, width of the fill-level output; must be at least log2(DEPTH)+1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data/in_last/in_bytes valid
- in_ready  out  1  packer can accept a word this cycle
- in_data  in  32  input word; byte 0 in bits [31:24]
- in_last  in  1  word is the final word of the message
- in_bytes  in  2  valid bytes in the last word (0 means 4); ignored unless in_last
- blk_valid  out  1  FIFO head holds a complete block
- blk_ready  in  1  AES core accepts the head block
- blk_data  out  128  head block; first word in [127:96]
- blk_last  out  1  head block is the final block of its message
- fill_level  out  CNT_W  number of blocks currently buffered

Behaviour:
- Reset (async, active-high):
  - Clears word index, FIFO pointers/count, and pack register; state returns to FILL.
  - Output values during and after reset: blk_valid=0, blk_data=0, blk_last=0, fill_level=0, in_ready=1.
- Accept/pop rules:
  - A word is accepted on in_valid && in_ready.
  - in_ready = (state==FILL) && (count < DEPTH). It is a function of registered state only; a same-cycle pop does not raise it.
- Packing:
  - A 2-bit word_idx selects the lane: idx 0 -> [127:96], 1 -> [95:64], 2 -> [63:32], 3 -> [31:0].
  - The block is pushed into the FIFO on acceptance of idx 3, or on acceptance of any word with in_last=1.
  - word_idx wraps to 0 after a push. Pushed blk_last = in_last of the pushing word.
- Final partial block:
  - Without the optional feature: all bytes after the last valid byte are 0x00.
  - Valid byte count = 4*word_idx + (in_bytes==0 ? 4 : in_bytes).
- Latency: blk_valid rises the cycle after the accept that completes a block, provided the FIFO was empty.
- Output side:
  - blk_valid = (count != 0). blk_data and blk_last reflect the FIFO head combinationally from registered storage.
  - Pop on blk_valid && blk_ready.
  - blk_data must hold stable while blk_valid=1 && blk_ready=0.
- Simultaneous push and pop: count is unchanged and pointers both advance. When count==DEPTH, no push can occur.
- FIFO pointer wrap: pointers are modulo DEPTH and wrap naturally.
- States:
  - FILL: normal packing.
  - PAD: exists only with the optional feature.
  - Transitions are listed under Optional Feature.
- in_last on word 0 with in_bytes=1: valid block, 1 data byte, rest fill.
- Reset mid-block: the partial pack register is discarded with no push.

Optional Feature:
- Macro: AES_PKCS7_PAD_EN.
- With it defined:
  - Fill bytes of the final block equal N = 16 - valid_bytes (PKCS#7).
  - If the last word exactly completes a block (valid_bytes=16), that block is pushed with blk_last=0.
  - The FSM then enters PAD. In PAD, in_ready=0, and when count<DEPTH an all-0x10 block is pushed with blk_last=1. The FSM then returns to FILL.
- Without it: zero fill; the PAD state and its logic are absent; an exactly-full last block carries blk_last=1.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLK_W=128 and AES_WORD_W=32.
  - The FSM state encoding (ST_FILL, ST_PAD).
  - A pad-byte function mapping valid-byte count to the fill byte.
- One sub-module, aes_blk_fifo: parameterised DEPTH x 128-bit storage plus a last bit, with push/pop/count, used by the packer.

Test Plan:
- Reset release, then words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF (last on word 4, in_bytes=0), blk_ready=1.
  - blk_valid one cycle after the 4th accept.
  - blk_data=0x00112233445566778899AABBCCDDEEFF, blk_last=1.
- Partial last word: 0xDEADBEEF then 0xCAFE0000 with in_last=1, in_bytes=2.
  - Without macro: block 0xDEADBEEFCAFE00000000000000000000.
  - With macro: tail bytes are 0x0A, giving 0xDEADBEEFCAFE0A0A0A0A0A0A0A0A0A0A.
- Backpressure: blk_ready=0, stream 12 words.
  - After 2 blocks: fill_level=2, in_ready=0, and the 9th word stalls.
  - blk_data stays stable; raising blk_ready drains blocks in order.
- Simultaneous push/pop at count=1: fill_level stays 1 and ordering is preserved.
- With AES_PKCS7_PAD_EN, exact 16-byte message:
  - Data block is pushed with blk_last=0.
  - Then a 0x1010...10 block with blk_last=1.
  - in_ready is low during PAD.
- Assert reset after 2 words: all outputs return to reset values; the next 4 words form a clean new block.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES packer definitions: widths, FSM state encoding and the fill-byte rule.
// The fill byte depends on AES_PKCS7_PAD_EN (PKCS#7 count when defined, zero otherwise).
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PAD  = 1'b1
    } state_e;

    // Byte written after the last valid byte of a final block
    function automatic logic [7:0] pad_byte(input logic [4:0] valid_bytes);
`ifdef AES_PKCS7_PAD_EN
        return 8'(5'd16 - valid_bytes);
`else
        return (valid_bytes == 5'd0) ? 8'h00 : 8'h00;
`endif
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Small DEPTH x 128-bit block FIFO with a per-entry last flag.
// Head entry is presented combinationally from registered storage.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [AES_BLK_W-1:0] push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic [AES_BLK_W-1:0] head_data,
    output logic                 head_last,
    output logic [CNT_W-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [AES_BLK_W-1:0] data_q [DEPTH];
    logic [AES_BLK_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]     last_q, last_d;
    logic                 do_push;
    logic                 do_pop;

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            data_q   <= data_d;
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/aes_block_packer.sv
// Packs a 32-bit word stream into 128-bit AES blocks and buffers them for the core.
// Define AES_PKCS7_PAD_EN for PKCS#7 fill and the trailing all-0x10 pad block.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AES_WORD_W-1:0] in_data,
    input  logic                  in_last,
    input  logic [1:0]            in_bytes,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [AES_BLK_W-1:0]  blk_data,
    output logic                  blk_last,
    output logic [CNT_W-1:0]      fill_level
);

    state_e               state_q, state_d;
    logic [1:0]           word_idx_q, word_idx_d;
    logic [AES_BLK_W-1:0] pack_q, pack_d;
    logic [AES_BLK_W-1:0] merged;
    logic [AES_BLK_W-1:0] push_data;
    logic [4:0]           valid_bytes;
    logic [CNT_W-1:0]     count;
    logic                 accept;
    logic                 push;
    logic                 push_last;
    logic                 pop;

    always_comb begin
        in_ready    = (state_q == ST_FILL) && (count < CNT_W'(DEPTH));
        accept      = in_valid && in_ready;
        valid_bytes = {1'b0, word_idx_q, 2'b00}
                    + ((in_bytes == 2'd0) ? 5'd4 : {3'b000, in_bytes});
        merged      = pack_q;
        merged[AES_BLK_W-1-AES_WORD_W*word_idx_q -: AES_WORD_W] = in_data;
        // Everything past the last valid byte of a final block becomes fill
        if (in_last) begin
            for (int b = 0; b < AES_BLK_W / 8; b++) begin
                if (5'(b) >= valid_bytes) begin
                    merged[AES_BLK_W-1-8*b -: 8] = pad_byte(valid_bytes);
                end
            end
        end

        state_d    = state_q;
        word_idx_d = word_idx_q;
        pack_d     = pack_q;
        push       = 1'b0;
        push_data  = merged;
        push_last  = in_last;

        if (accept) begin
            if ((word_idx_q == 2'd3) || in_last) begin
                push       = 1'b1;
                word_idx_d = 2'd0;
                pack_d     = '0;
`ifdef AES_PKCS7_PAD_EN
                // An exactly full final block still needs a whole pad block after it
                if (in_last && (valid_bytes == 5'd16)) begin
                    push_last = 1'b0;
                    state_d   = ST_PAD;
                end
`endif
            end else begin
                word_idx_d = word_idx_q + 2'd1;
                pack_d     = merged;
            end
        end

`ifdef AES_PKCS7_PAD_EN
        if ((state_q == ST_PAD) && (count < CNT_W'(DEPTH))) begin
            push      = 1'b1;
            push_data = {(AES_BLK_W / 8){pad_byte(5'd0)}};
            push_last = 1'b1;
            state_d   = ST_FILL;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            word_idx_q <= '0;
            pack_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            pack_q     <= pack_d;
        end
    end

    assign blk_valid  = (count != '0);
    assign pop        = blk_valid && blk_ready;
    assign fill_level = count;

    aes_blk_fifo #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .push_last (push_last),
        .pop       (pop),
        .head_data (blk_data),
        .head_last (blk_last),
        .count     (count)
    );

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed scenarios plus randomized messages
// against a byte-level message model (honours AES_PKCS7_PAD_EN when defined).
module tb_aes_block_packer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         blk_last;
    logic [CNT_W-1:0] fill_level;

    int checks   = 0;
    int failures = 0;

    blk_t       exp_q[$];
    logic [7:0] msg_bytes[16];
    int         msg_words   = 0;
    bit         pad_pending = 0;
    bit         acc         = 0;
    bit         rnd_ready   = 0;
    logic [127:0] saved_head;

    aes_block_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Message model: collect bytes, emit a block every 16 bytes or at the message end
    task automatic model_accept(input logic [31:0] d, input logic l, input logic [1:0] b);
        int   vb;
        blk_t blk;
        for (int k = 0; k < 4; k++) msg_bytes[4*msg_words+k] = d[31-8*k -: 8];
        if (l || msg_words == 3) begin
            vb = l ? (4*msg_words + ((b == 2'd0) ? 4 : int'(b))) : 16;
            for (int i = 0; i < 16; i++) begin
`ifdef AES_PKCS7_PAD_EN
                blk.data[127-8*i -: 8] = (i < vb) ? msg_bytes[i] : 8'(16 - vb);
`else
                blk.data[127-8*i -: 8] = (i < vb) ? msg_bytes[i] : 8'h00;
`endif
            end
            blk.last = l;
`ifdef AES_PKCS7_PAD_EN
            if (l && vb == 16) begin
                blk.last    = 1'b0;
                pad_pending = 1;
            end
`endif
            exp_q.push_back(blk);
            msg_words = 0;
        end else begin
            msg_words++;
        end
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return after the rising edge
    task automatic cycle();
        int   pre;
        blk_t pad;
        @(negedge clk);
        pre = exp_q.size();
        check_output("blk_valid", 128'(blk_valid), 128'(pre != 0));
        check_output("fill_level", 128'(fill_level), 128'(pre));
        check_output("in_ready", 128'(in_ready), 128'(!pad_pending && pre < DEPTH));
        if (pre != 0) begin
            check_output("head_data", blk_data, exp_q[0].data);
            check_output("head_last", 128'(blk_last), 128'(exp_q[0].last));
        end
        acc = in_valid && in_ready;
        if (pre != 0 && blk_ready) void'(exp_q.pop_front());
        if (pad_pending && pre < DEPTH) begin
            pad.data = {16{8'h10}};
            pad.last = 1'b1;
            exp_q.push_back(pad);
            pad_pending = 0;
        end
        if (acc) model_accept(in_data, in_last, in_bytes);
        @(posedge clk);
        #1;
        if (rnd_ready) blk_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic apply_stimulus(input logic [31:0] d, input logic l, input logic [1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        acc      = 0;
        while (!acc && n < 60) begin
            cycle();
            n++;
        end
        check_output("accept_timeout", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rnd_ready = 0;
        blk_ready = 1'b1;
        while ((exp_q.size() != 0 || pad_pending) && n < 100) begin
            cycle();
            n++;
        end
        check_output("drain_timeout", 128'(exp_q.size()), 128'(0));
        blk_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        #2;
        check_output("rst_blk_valid", 128'(blk_valid), 128'(0));
        check_output("rst_blk_data", blk_data, 128'(0));
        check_output("rst_blk_last", 128'(blk_last), 128'(0));
        check_output("rst_fill_level", 128'(fill_level), 128'(0));
        check_output("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        msg_words   = 0;
        pad_pending = 0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = '0;
        blk_ready = 1'b0;
        #1;
        do_reset();

        // Full 4-word message, held at the head before the core takes it
        apply_stimulus(32'h00112233, 1'b0, 2'd0);
        apply_stimulus(32'h44556677, 1'b0, 2'd0);
        apply_stimulus(32'h8899AABB, 1'b0, 2'd0);
        apply_stimulus(32'hCCDDEEFF, 1'b1, 2'd0);
        check_output("t1_valid", 128'(blk_valid), 128'(1));
        check_output("t1_data", blk_data, 128'h00112233445566778899AABBCCDDEEFF);
        check_output("t1_last", 128'(blk_last), 128'(1));
        drain();

        // Partial last word
        apply_stimulus(32'hDEADBEEF, 1'b0, 2'd0);
        apply_stimulus(32'hCAFE0000, 1'b1, 2'd2);
`ifdef AES_PKCS7_PAD_EN
        check_output("t2_data", blk_data, 128'hDEADBEEFCAFE0A0A0A0A0A0A0A0A0A0A);
`else
        check_output("t2_data", blk_data, 128'hDEADBEEFCAFE00000000000000000000);
`endif
        check_output("t2_last", 128'(blk_last), 128'(1));
        drain();

        // Backpressure: two full blocks fill the FIFO, the 9th word must stall
        for (int w = 0; w < 8; w++) apply_stimulus(32'h10000000 + 32'(w), 1'b0, 2'd0);
        check_output("bp_fill", 128'(fill_level), 128'(2));
        check_output("bp_in_ready", 128'(in_ready), 128'(0));
        saved_head = blk_data;
        in_valid = 1'b1;
        in_data  = 32'h10000008;
        in_last  = 1'b0;
        in_bytes = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_output("bp_stall", 128'(acc), 128'(0));
            check_output("bp_stable", blk_data, saved_head);
        end
        blk_ready = 1'b1;
        for (int w = 8; w < 12; w++) apply_stimulus(32'h10000000 + 32'(w), (w == 11), 2'd0);
        drain();

        // Push and pop in the same cycle with one block buffered
        for (int w = 0; w < 7; w++) apply_stimulus(32'h20000000 + 32'(w), 1'b0, 2'd0);
        check_output("pp_pre_fill", 128'(fill_level), 128'(1));
        blk_ready = 1'b1;
        apply_stimulus(32'h20000007, 1'b0, 2'd0);
        check_output("pp_fill", 128'(fill_level), 128'(1));
        drain();

`ifdef AES_PKCS7_PAD_EN
        // Exactly 16-byte message gets a separate pad block
        for (int w = 0; w < 4; w++) apply_stimulus(32'h30000000 + 32'(w), (w == 3), 2'd0);
        check_output("pad_data_last", 128'(blk_last), 128'(0));
        check_output("pad_in_ready", 128'(in_ready), 128'(0));
        cycle();
        check_output("pad_fill", 128'(fill_level), 128'(2));
        drain();
`endif

        // Reset mid-block discards the partial block
        apply_stimulus(32'h40404040, 1'b0, 2'd0);
        apply_stimulus(32'h41414141, 1'b0, 2'd0);
        do_reset();
        apply_stimulus(32'h01020304, 1'b0, 2'd0);
        apply_stimulus(32'h05060708, 1'b0, 2'd0);
        apply_stimulus(32'h090A0B0C, 1'b0, 2'd0);
        apply_stimulus(32'h0D0E0F10, 1'b0, 2'd0);
        check_output("rst_new_block", blk_data, 128'h0102030405060708090A0B0C0D0E0F10);
        check_output("rst_new_last", 128'(blk_last), 128'(0));
        drain();

        // Randomized messages with random core backpressure and input gaps
        rnd_ready = 1;
        for (int m = 0; m < 40; m++) begin
            int nw = $urandom_range(1, 9);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    cycle();
                end
                apply_stimulus($urandom, (w == nw - 1), 2'($urandom_range(0, 3)));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
